// File: rtl/line_dispatcher.sv
// Line-command dispatcher: walks the rows of a tile and issues one line command per row,
// with per-lane start addresses, spacing commands by at least two cycles.
module line_dispatcher #(
  parameter int X_MAC        = 4,
  parameter int ADDR_LEN     = 13,
  parameter int MAX_LINE_LEN = 10,
  parameter int ROW_LEN      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_LEN-1:0]       cfg_base_addr,
  input  logic [ADDR_LEN-1:0]       cfg_lane_stride,
  input  logic [ADDR_LEN-1:0]       cfg_row_stride,
  input  logic [ROW_LEN-1:0]        cfg_num_rows,
  input  logic [MAX_LINE_LEN-1:0]   cfg_linelen,
  input  logic                      cfg_ispad,
  input  logic                      cfg_tofifo,
  input  logic                      cfg_fromfifo,
  input  logic                      ready,
  input  logic                      idle_soon,
  output logic                      valid,
  output logic [ADDR_LEN*X_MAC-1:0] st_addr,
  output logic [MAX_LINE_LEN-1:0]   linelen,
  output logic                      ispad,
  output logic                      tofifo,
  output logic                      fromfifo,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [ADDR_LEN-1:0]       r_lane_stride, w_lane_stride_nxt;
  logic [ADDR_LEN-1:0]       r_row_stride, w_row_stride_nxt;
  logic [ROW_LEN-1:0]        r_num_rows, w_num_rows_nxt;
  logic [MAX_LINE_LEN-1:0]   r_cfg_linelen, w_cfg_linelen_nxt;
  logic                      r_cfg_ispad, w_cfg_ispad_nxt;
  logic                      r_cfg_tofifo, w_cfg_tofifo_nxt;
  logic                      r_cfg_fromfifo, w_cfg_fromfifo_nxt;
  logic [ROW_LEN-1:0]        r_row, w_row_nxt;
  logic [ADDR_LEN-1:0]       r_row_addr, w_row_addr_nxt;
  logic                      r_valid, w_valid_nxt;
  logic [ADDR_LEN*X_MAC-1:0] r_st_addr, w_st_addr_nxt;
  logic [MAX_LINE_LEN-1:0]   r_linelen, w_linelen_nxt;
  logic                      r_ispad, w_ispad_nxt;
  logic                      r_tofifo, w_tofifo_nxt;
  logic                      r_fromfifo, w_fromfifo_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_done, w_done_nxt;

  logic [ROW_LEN-1:0]        w_row_inc;
  logic [ADDR_LEN-1:0]       w_acc;
  logic [ADDR_LEN*X_MAC-1:0] w_lane_addr;

  assign w_row_inc = r_row + 1'b1;

  // Lane addresses of the current row; sums wrap at the address width.
  always_comb begin
    w_acc       = r_row_addr;
    w_lane_addr = '0;
    for (int j = 0; j < X_MAC; j++) begin
      w_lane_addr[j*ADDR_LEN +: ADDR_LEN] = w_acc;
      w_acc = w_acc + r_lane_stride;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt        = r_state;
    w_lane_stride_nxt  = r_lane_stride;
    w_row_stride_nxt   = r_row_stride;
    w_num_rows_nxt     = r_num_rows;
    w_cfg_linelen_nxt  = r_cfg_linelen;
    w_cfg_ispad_nxt    = r_cfg_ispad;
    w_cfg_tofifo_nxt   = r_cfg_tofifo;
    w_cfg_fromfifo_nxt = r_cfg_fromfifo;
    w_row_nxt          = r_row;
    w_row_addr_nxt     = r_row_addr;
    w_valid_nxt        = 1'b0;
    w_st_addr_nxt      = r_st_addr;
    w_linelen_nxt      = r_linelen;
    w_ispad_nxt        = r_ispad;
    w_tofifo_nxt       = r_tofifo;
    w_fromfifo_nxt     = r_fromfifo;
    w_busy_nxt         = r_busy;
    w_done_nxt         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_lane_stride_nxt  = cfg_lane_stride;
          w_row_stride_nxt   = cfg_row_stride;
          w_num_rows_nxt     = cfg_num_rows;
          w_cfg_linelen_nxt  = cfg_linelen;
          w_cfg_ispad_nxt    = cfg_ispad;
          w_cfg_tofifo_nxt   = cfg_tofifo;
          w_cfg_fromfifo_nxt = cfg_fromfifo;
          w_row_nxt          = '0;
          w_row_addr_nxt     = cfg_base_addr;
          w_busy_nxt         = 1'b1;
          w_state_nxt        = (cfg_num_rows == '0) ? S_FIN : S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (idle_soon) begin
          w_valid_nxt    = 1'b1;
          w_st_addr_nxt  = w_lane_addr;
          w_linelen_nxt  = r_cfg_linelen;
          w_ispad_nxt    = r_cfg_ispad;
          // First row has no upstream FIFO data; last row has no downstream consumer.
          w_tofifo_nxt   = r_cfg_tofifo & (w_row_inc != r_num_rows);
          w_fromfifo_nxt = r_cfg_fromfifo & (r_row != '0);
          w_state_nxt    = S_GAP;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_GAP: begin
        w_row_nxt      = w_row_inc;
        w_row_addr_nxt = r_row_addr + r_row_stride;
        w_state_nxt    = (w_row_inc == r_num_rows) ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: begin
        if (!ready) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_lane_stride  <= '0;
      r_row_stride   <= '0;
      r_num_rows     <= '0;
      r_cfg_linelen  <= '0;
      r_cfg_ispad    <= 1'b0;
      r_cfg_tofifo   <= 1'b0;
      r_cfg_fromfifo <= 1'b0;
      r_row          <= '0;
      r_row_addr     <= '0;
      r_valid        <= 1'b0;
      r_st_addr      <= '0;
      r_linelen      <= '0;
      r_ispad        <= 1'b0;
      r_tofifo       <= 1'b0;
      r_fromfifo     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_lane_stride  <= w_lane_stride_nxt;
      r_row_stride   <= w_row_stride_nxt;
      r_num_rows     <= w_num_rows_nxt;
      r_cfg_linelen  <= w_cfg_linelen_nxt;
      r_cfg_ispad    <= w_cfg_ispad_nxt;
      r_cfg_tofifo   <= w_cfg_tofifo_nxt;
      r_cfg_fromfifo <= w_cfg_fromfifo_nxt;
      r_row          <= w_row_nxt;
      r_row_addr     <= w_row_addr_nxt;
      r_valid        <= w_valid_nxt;
      r_st_addr      <= w_st_addr_nxt;
      r_linelen      <= w_linelen_nxt;
      r_ispad        <= w_ispad_nxt;
      r_tofifo       <= w_tofifo_nxt;
      r_fromfifo     <= w_fromfifo_nxt;
      r_busy         <= w_busy_nxt;
      r_done         <= w_done_nxt;
    end
  end

  assign valid    = r_valid;
  assign st_addr  = r_st_addr;
  assign linelen  = r_linelen;
  assign ispad    = r_ispad;
  assign tofifo   = r_tofifo;
  assign fromfifo = r_fromfifo;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_line_dispatcher.sv
// Self-checking bench for line_dispatcher: event-level reference model with a per-cycle
// compare, directed literal scenarios, then randomized tiles.
module tb_line_dispatcher;
  localparam int XM = 4;
  localparam int AL = 13;
  localparam int ML = 10;
  localparam int RL = 10;
  localparam int SW = AL * XM;

  logic          clk, rst_n, start;
  logic [AL-1:0] cfg_base_addr, cfg_lane_stride, cfg_row_stride;
  logic [RL-1:0] cfg_num_rows;
  logic [ML-1:0] cfg_linelen;
  logic          cfg_ispad, cfg_tofifo, cfg_fromfifo;
  logic          ready, idle_soon;
  logic          valid, ispad, tofifo, fromfifo, busy, done;
  logic [SW-1:0] st_addr;
  logic [ML-1:0] linelen;

  line_dispatcher #(.X_MAC(XM), .ADDR_LEN(AL), .MAX_LINE_LEN(ML), .ROW_LEN(RL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_lane_stride(cfg_lane_stride),
    .cfg_row_stride(cfg_row_stride), .cfg_num_rows(cfg_num_rows),
    .cfg_linelen(cfg_linelen), .cfg_ispad(cfg_ispad), .cfg_tofifo(cfg_tofifo),
    .cfg_fromfifo(cfg_fromfifo), .ready(ready), .idle_soon(idle_soon),
    .valid(valid), .st_addr(st_addr), .linelen(linelen), .ispad(ispad),
    .tofifo(tofifo), .fromfifo(fromfifo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [SW-1:0] st;
    logic [ML-1:0] ll;
    logic          ip;
    logic          tf;
    logic          ff;
  } cmd_t;

  typedef struct {
    int            c;
    logic [SW-1:0] st;
    logic          tf;
    logic          ff;
  } ev_t;

  // Reference model: a tile is a list of commands; each is issued at the first edge that is
  // at least two edges after the previous one (one after start) with idle_soon high.
  cmd_t mq[$];
  logic m_active = 1'b0;
  int   m_earliest = 0;
  int   m_drain_from = 0;
  int   m_fin_at = -1;
  logic e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  cmd_t e_cmd = '0;

  always @(posedge clk) begin
    cmd_t c;
    logic [AL-1:0] a;
    cyc = cyc + 1;
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_active = 1'b0;
      e_busy   = 1'b0;
      e_cmd    = '0;
      m_fin_at = -1;
    end else if (!m_active) begin
      if (start) begin
        for (int r = 0; r < int'(cfg_num_rows); r++) begin
          c = '0;
          for (int j = 0; j < XM; j++) begin
            a = AL'(int'(cfg_base_addr) + r * int'(cfg_row_stride) + j * int'(cfg_lane_stride));
            c.st[j*AL +: AL] = a;
          end
          c.ll = cfg_linelen;
          c.ip = cfg_ispad;
          c.tf = cfg_tofifo && (r != int'(cfg_num_rows) - 1);
          c.ff = cfg_fromfifo && (r != 0);
          mq.push_back(c);
        end
        m_active   = 1'b1;
        e_busy     = 1'b1;
        m_earliest = cyc + 1;
        m_fin_at   = (cfg_num_rows == '0) ? cyc + 1 : -1;
      end
    end else if (m_fin_at >= 0) begin
      if (cyc == m_fin_at) begin
        e_done   = 1'b1;
        e_busy   = 1'b0;
        m_active = 1'b0;
        m_fin_at = -1;
      end
    end else if (mq.size() > 0) begin
      if (cyc >= m_earliest && idle_soon) begin
        e_cmd      = mq.pop_front();
        e_valid    = 1'b1;
        m_earliest = cyc + 2;
        if (mq.size() == 0) m_drain_from = cyc + 2;
      end
    end else if (cyc >= m_drain_from && !ready) begin
      m_fin_at = cyc + 1;
    end
  end

  // Compare process: every output against the model on every cycle, away from the edge.
  ev_t  vlog[$];
  int   dlog[$];
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("valid", 64'(valid), 64'(e_valid));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("st_addr", 64'(st_addr), 64'(e_cmd.st));
      chk("linelen", 64'(linelen), 64'(e_cmd.ll));
      chk("ispad", 64'(ispad), 64'(e_cmd.ip));
      chk("tofifo", 64'(tofifo), 64'(e_cmd.tf));
      chk("fromfifo", 64'(fromfifo), 64'(e_cmd.ff));
      if (prev_valid === 1'b1 && valid === 1'b1) chk("valid_spacing", 64'(valid), 64'd0);
      prev_valid = valid;
      if (valid === 1'b1) vlog.push_back('{cyc, st_addr, tofifo, fromfifo});
      if (done === 1'b1) dlog.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input logic [AL-1:0] b, input logic [AL-1:0] ls, input logic [AL-1:0] rs,
                    input logic [RL-1:0] nr, input logic [ML-1:0] ll,
                    input logic ip, input logic tf, input logic ff, output int s);
    @(negedge clk);
    cfg_base_addr = b; cfg_lane_stride = ls; cfg_row_stride = rs; cfg_num_rows = nr;
    cfg_linelen = ll; cfg_ispad = ip; cfg_tofifo = tf; cfg_fromfifo = ff;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    cfg_base_addr   = AL'($urandom);
    cfg_lane_stride = AL'($urandom);
    cfg_row_stride  = AL'($urandom);
    cfg_num_rows    = RL'($urandom);
    cfg_linelen     = ML'($urandom);
  endtask

  task automatic wait_done(input int limit, input bit rnd);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      if (rnd) begin
        idle_soon = ($urandom_range(0, 99) < 60);
        ready     = ($urandom_range(0, 99) < 50);
        start     = ($urandom_range(0, 19) == 0);
        cfg_num_rows  = RL'($urandom_range(0, 5));
        cfg_base_addr = AL'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (done !== 1'b1) chk("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int s, vb, db, rise;
  logic [SW-1:0] t1_st [3];
  logic          t1_tf [3];
  logic          t1_ff [3];
  logic [SW-1:0] exp_wrap;

  initial begin
    rst_n = 1'b0; start = 1'b0; idle_soon = 1'b0; ready = 1'b0;
    cfg_base_addr = '0; cfg_lane_stride = '0; cfg_row_stride = '0; cfg_num_rows = '0;
    cfg_linelen = '0; cfg_ispad = 1'b0; cfg_tofifo = 1'b0; cfg_fromfifo = 1'b0;
    repeat (3) tick();
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_st_addr", 64'(st_addr), 64'd0);
    rst_n = 1'b1;

    // Basic tile: addresses, spacing and FIFO flags.
    t1_st[0] = {13'h1C0, 13'h180, 13'h140, 13'h100};
    t1_st[1] = {13'h1C2, 13'h182, 13'h142, 13'h102};
    t1_st[2] = {13'h1C4, 13'h184, 13'h144, 13'h104};
    t1_tf = '{1'b1, 1'b1, 1'b0};
    t1_ff = '{1'b0, 1'b1, 1'b1};
    idle_soon = 1'b1; ready = 1'b0;
    vb = vlog.size(); db = dlog.size();
    go(13'h100, 13'h040, 13'h002, 10'd3, 10'd77, 1'b1, 1'b1, 1'b1, s);
    wait_done(50, 1'b0);
    tick();
    chk("t1_count", 64'(vlog.size() - vb), 64'd3);
    if (vlog.size() - vb == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_cycle", 64'(vlog[vb+i].c), 64'(s + 1 + 2*i));
        chk("t1_st", 64'(vlog[vb+i].st), 64'(t1_st[i]));
        chk("t1_tofifo", 64'(vlog[vb+i].tf), 64'(t1_tf[i]));
        chk("t1_fromfifo", 64'(vlog[vb+i].ff), 64'(t1_ff[i]));
      end
    end
    chk("t1_done_count", 64'(dlog.size() - db), 64'd1);
    if (dlog.size() > db) chk("t1_done_cycle", 64'(dlog[db]), 64'(s + 8));

    // Stall before row 1.
    vb = vlog.size();
    go(13'h010, 13'h001, 13'h001, 10'd2, 10'd5, 1'b0, 1'b0, 1'b0, s);
    tick();
    idle_soon = 1'b0;
    repeat (10) tick();
    rise = cyc;
    idle_soon = 1'b1;
    wait_done(50, 1'b0);
    tick();
    chk("t2_count", 64'(vlog.size() - vb), 64'd2);
    if (vlog.size() - vb == 2) begin
      chk("t2_row0_cycle", 64'(vlog[vb].c), 64'(s + 1));
      chk("t2_row1_cycle", 64'(vlog[vb+1].c), 64'(rise + 1));
    end

    // Zero-row tile.
    vb = vlog.size();
    go(13'h000, 13'h000, 13'h000, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, s);
    chk("t3_busy_first", 64'(busy), 64'd1);
    chk("t3_done_first", 64'(done), 64'd0);
    tick();
    chk("t3_busy_second", 64'(busy), 64'd0);
    chk("t3_done_second", 64'(done), 64'd1);
    tick();
    chk("t3_done_third", 64'(done), 64'd0);
    chk("t3_no_valid", 64'(vlog.size() - vb), 64'd0);

    // Lane address wrap.
    vb = vlog.size();
    exp_wrap = {13'h0002, 13'h0001, 13'h0000, 13'h1FFF};
    go(13'h1FFF, 13'h0001, 13'h0005, 10'd1, 10'd9, 1'b1, 1'b1, 1'b1, s);
    wait_done(50, 1'b0);
    tick();
    chk("t4_count", 64'(vlog.size() - vb), 64'd1);
    if (vlog.size() > vb) chk("t4_wrap_st", 64'(vlog[vb].st), 64'(exp_wrap));

    // Start while busy is ignored.
    vb = vlog.size(); db = dlog.size();
    go(13'h0AA, 13'h003, 13'h007, 10'd4, 10'd3, 1'b0, 1'b0, 1'b0, s);
    tick(); tick();
    cfg_base_addr = 13'h555; cfg_num_rows = 10'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50, 1'b0);
    repeat (5) tick();
    chk("t5_count", 64'(vlog.size() - vb), 64'd4);
    if (vlog.size() - vb == 4) begin
      chk("t5_first_lane0", 64'(vlog[vb].st[AL-1:0]), 64'h0AA);
      chk("t5_last_lane0", 64'(vlog[vb+3].st[AL-1:0]), 64'h0BF);
    end
    chk("t5_done_count", 64'(dlog.size() - db), 64'd1);

    // Reset mid-tile after row 1.
    vb = vlog.size(); db = dlog.size();
    go(13'h200, 13'h010, 13'h020, 10'd3, 10'd12, 1'b1, 1'b1, 1'b1, s);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 64'(valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_st", 64'(st_addr), 64'd0);
    chk("t6_rst_fields", 64'({linelen, ispad, tofifo, fromfifo}), 64'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t6_valid_count", 64'(vlog.size() - vb), 64'd2);
    chk("t6_no_done", 64'(dlog.size() - db), 64'd0);

    // Randomized tiles.
    for (int t = 0; t < 40; t++) begin
      idle_soon = $urandom_range(0, 1) == 1;
      ready = $urandom_range(0, 1) == 1;
      go(AL'($urandom), AL'($urandom), AL'($urandom), RL'($urandom_range(0, 6)),
         ML'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), s);
      wait_done(400, 1'b1);
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
